// File: rtl/gba_pak_emulator.sv
// GBA cartridge-bus ROM responder.
// On a CS falling edge the block latches the 24-bit word address from AD/A-hi.
// It fetches each word from a word-wide memory port ahead of time.
// Each RD low pulse drives one fetched word onto AD, then the address advances
// and the next word is prefetched.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | bus deselected, waiting for a CS falling edge
// FETCH   | memory request outstanding for the current address
// WAIT_RD | word buffered, waiting for an RD falling edge
// DRIVE   | word on AD while RD is low; RD rising advances the address
module gba_pak_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pin_gbaRD,
  input  logic        pin_gbaWR,
  input  logic        pin_gbaCS,
  input  logic        pin_gbaCS2,
  inout  wire  [15:0] pin_gbaDataAddressLo,
  input  logic [7:0]  pin_gbaAddressHi,
  output logic [23:0] mem_Address,
  output logic        mem_Request,
  input  logic        mem_Ready,
  input  logic [15:0] mem_Data,
  output logic [24:0] stat_ReadCount,
  output logic        stat_Underrun
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT_RD, S_DRIVE} state_t;

  // Strobes idle high, so the synchronizer resets to "deasserted" and no
  // edge is seen when reset is released with the bus idle.
  localparam logic [27:0] SYNC_RST  = {4'b1111, 24'h000000};
  localparam logic [23:0] ADDR_MASK = 24'((33'd1 << ADDR_BITS) - 33'd1);

  // Packed pins: [15:0] AD, [23:16] A-hi, [24] CS, [25] RD, [26] WR, [27] CS2
  logic [27:0] w_pins;
  logic [27:0] r_sync [SYNC_STAGES];
  logic [27:0] w_sync;
  logic [23:0] w_bus_s;
  logic        w_cs_s, w_rd_s, w_wr_s, w_unused_cs2;
  logic        r_cs_q, r_rd_q;
  logic        w_cs_fall, w_cs_rise, w_rd_fall, w_rd_rise;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_addr, w_addr_nxt;
  logic [15:0] r_word_buf, w_word_buf_nxt;
  logic [15:0] r_out_word, w_out_word_nxt;
  logic [24:0] r_count, w_count_nxt;
  logic        r_underrun, w_underrun_nxt;
  logic        r_late, w_late_nxt;
  logic        r_mem_req;
  logic        r_drive_en;

  assign w_pins = {pin_gbaCS2, pin_gbaWR, pin_gbaRD, pin_gbaCS,
                   pin_gbaAddressHi, pin_gbaDataAddressLo};

  // Equal-depth synchronizer chain for every bus pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync       = r_sync[SYNC_STAGES-1];
  assign w_bus_s      = w_sync[23:0];
  assign w_cs_s       = w_sync[24];
  assign w_rd_s       = w_sync[25];
  assign w_wr_s       = w_sync[26];
  // CS2 (SRAM select) has no effect on this ROM responder.
  assign w_unused_cs2 = w_sync[27];

  // Previous synchronized strobe values for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_q <= 1'b1;
      r_rd_q <= 1'b1;
    end else begin
      r_cs_q <= w_cs_s;
      r_rd_q <= w_rd_s;
    end
  end

  assign w_cs_fall = r_cs_q & ~w_cs_s;
  assign w_cs_rise = ~r_cs_q & w_cs_s;
  assign w_rd_fall = r_rd_q & ~w_rd_s;
  assign w_rd_rise = ~r_rd_q & w_rd_s;

  // Next-state logic; CS release overrides everything else.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_word_buf_nxt = r_word_buf;
    w_out_word_nxt = r_out_word;
    w_count_nxt    = r_count;
    w_underrun_nxt = r_underrun;
    w_late_nxt     = r_late;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
      w_late_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            w_addr_nxt  = w_bus_s & ADDR_MASK;
            w_late_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_rd_fall) begin
            w_underrun_nxt = 1'b1;
            w_late_nxt     = 1'b1;
          end
          // A missed RD pulse that already ended leaves the word buffered.
          if (w_rd_rise) w_late_nxt = 1'b0;
          if (r_mem_req && mem_Ready) begin
            w_word_buf_nxt = mem_Data;
            w_late_nxt     = 1'b0;
            if ((r_late || w_rd_fall) && !w_rd_s) begin
              w_out_word_nxt = mem_Data;
              w_state_nxt    = S_DRIVE;
            end else begin
              w_state_nxt = S_WAIT_RD;
            end
          end
        end
        S_WAIT_RD: begin
          if (w_rd_fall) begin
            w_out_word_nxt = r_word_buf;
            w_state_nxt    = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (w_rd_rise) begin
            w_addr_nxt  = (r_addr + 24'd1) & ADDR_MASK;
            w_count_nxt = (r_count == '1) ? r_count : r_count + 25'd1;
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs; request and drive follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_word_buf <= '0;
      r_out_word <= '0;
      r_count    <= '0;
      r_underrun <= 1'b0;
      r_late     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_drive_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_word_buf <= w_word_buf_nxt;
      r_out_word <= w_out_word_nxt;
      r_count    <= w_count_nxt;
      r_underrun <= w_underrun_nxt;
      r_late     <= w_late_nxt;
      r_mem_req  <= (w_state_nxt == S_FETCH);
      r_drive_en <= (w_state_nxt == S_DRIVE) && !w_cs_s && !w_rd_s && w_wr_s;
    end
  end

  assign pin_gbaDataAddressLo = r_drive_en ? r_out_word : 16'hzzzz;
  assign mem_Address          = r_addr;
  assign mem_Request          = r_mem_req;
  assign stat_ReadCount       = r_count;
  assign stat_Underrun        = r_underrun;

endmodule

// File: tb/tb_gba_pak_emulator.sv
// Scoreboard bench for gba_pak_emulator: stimulus pushes the expected memory
// requests and driven words; independent monitors pop and compare.
module tb_gba_pak_emulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b1, wr = 1'b1, cs = 1'b1, cs2 = 1'b1;
  logic        tb_ad_en = 1'b0;
  logic [15:0] tb_ad = '0;
  logic [7:0]  ahi = '0;
  wire  [15:0] ad_bus;
  logic [23:0] mem_Address;
  logic        mem_Request;
  logic        mem_Ready = 1'b0;
  logic [15:0] mem_Data = '0;
  logic [24:0] stat_ReadCount;
  logic        stat_Underrun;

  assign ad_bus = tb_ad_en ? tb_ad : 16'hzzzz;

  gba_pak_emulator #(.SYNC_STAGES(2), .ADDR_BITS(24)) dut (
    .clk(clk), .reset(reset),
    .pin_gbaRD(rd), .pin_gbaWR(wr), .pin_gbaCS(cs), .pin_gbaCS2(cs2),
    .pin_gbaDataAddressLo(ad_bus), .pin_gbaAddressHi(ahi),
    .mem_Address(mem_Address), .mem_Request(mem_Request),
    .mem_Ready(mem_Ready), .mem_Data(mem_Data),
    .stat_ReadCount(stat_ReadCount), .stat_Underrun(stat_Underrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mem_lat = 1;
  bit          manual = 1'b0;
  logic [23:0] exp_req[$];
  logic [15:0] exp_word[$];
  logic [24:0] exp_count = '0;
  logic        exp_underrun = 1'b0;

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'hA55A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=%h required=none at %0t", name, act, $time);
  endtask

  // Memory responder: one ready pulse mem_lat clocks after each new request.
  initial begin
    logic        req_q;
    logic [23:0] a;
    req_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!manual && mem_Request && !req_q) begin
        a = mem_Address;
        repeat (mem_lat - 1) @(negedge clk);
        mem_Data  = mem_word(a);
        mem_Ready = 1'b1;
        @(negedge clk);
        mem_Ready = 1'b0;
      end
      req_q = mem_Request;
    end
  end

  // Request monitor: every new request address must match the next expected one.
  initial begin
    logic q;
    q = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_Request && !q) begin
        if (exp_req.size() == 0) unexpected("req_addr", {8'h0, mem_Address});
        else check("req_addr", {8'h0, mem_Address}, {8'h0, exp_req.pop_front()});
      end
      q = mem_Request;
    end
  end

  // Drive monitor: every start of AD drive must present the next expected word.
  initial begin
    logic q;
    q = 1'b0;
    forever begin
      @(negedge clk);
      if (dut.r_drive_en && !q) begin
        if (exp_word.size() == 0) unexpected("ad_word", {16'h0, ad_bus});
        else check("ad_word", {16'h0, ad_bus}, {16'h0, exp_word.pop_front()});
      end
      q = dut.r_drive_en;
    end
  end

  task automatic cs_select(input logic [23:0] a);
    @(negedge clk);
    tb_ad = a[15:0];
    ahi = a[23:16];
    tb_ad_en = 1'b1;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    tb_ad_en = 1'b0;
  endtask

  task automatic rd_pulse(input int rd_low, input int rd_high);
    rd = 1'b0;
    repeat (2) @(negedge clk);
    check("drive_early", dut.r_drive_en, 0);
    @(negedge clk);
    check("drive_on", dut.r_drive_en, 1);
    repeat (rd_low - 3) @(negedge clk);
    rd = 1'b1;
    repeat (4) @(negedge clk);
    check("drive_off", dut.r_drive_en, 0);
    repeat (rd_high - 4) @(negedge clk);
  endtask

  task automatic read_burst(input logic [23:0] a, input int n, input int lat,
                            input int rd_low, input int rd_high);
    logic [23:0] ai;
    mem_lat = lat;
    for (int i = 0; i <= n; i++) begin
      ai = a + 24'(i);
      exp_req.push_back(ai);
      if (i < n) exp_word.push_back(mem_word(ai));
    end
    cs_select(a);
    repeat (lat + 4) @(negedge clk);
    for (int p = 0; p < n; p++) rd_pulse(rd_low, rd_high);
    cs = 1'b1;
    exp_count = exp_count + 25'(n);
    repeat (lat + 8) @(negedge clk);
    check("read_count", 32'(stat_ReadCount), 32'(exp_count));
    check("underrun", stat_Underrun, exp_underrun);
  endtask

  initial begin
    logic [23:0] ra;
    int rn, rl, rlo, rhi;
    #100000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    n_bad++;
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [23:0] ra;
    int rn, rl, rlo, rhi;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req", mem_Request, 0);
    check("rst_addr", {8'h0, mem_Address}, 0);
    check("rst_count", 32'(stat_ReadCount), 0);
    check("rst_underrun", stat_Underrun, 0);
    check("rst_drive", dut.r_drive_en, 0);

    // single read, 4-word burst with prefetch, address wrap
    read_burst(24'h561234, 1, 3, 12, 10);
    read_burst(24'h000010, 4, 1, 8, 8);
    read_burst(24'hFFFFFF, 2, 2, 8, 8);

    // underrun: RD pulse ends before the slow fetch completes, nothing driven
    mem_lat = 20;
    exp_req.push_back(24'h00ABCD);
    cs_select(24'h00ABCD);
    rd = 1'b0;
    repeat (6) @(negedge clk);
    rd = 1'b1;
    repeat (25) @(negedge clk);
    check("late_nodrive", dut.r_drive_en, 0);
    cs = 1'b1;
    exp_underrun = 1'b1;
    repeat (25) @(negedge clk);
    check("underrun_set", stat_Underrun, 1);
    check("underrun_count", 32'(stat_ReadCount), 32'(exp_count));

    // underrun: fetch completes while RD still low, word driven late
    mem_lat = 8;
    exp_req.push_back(24'h123456);
    exp_req.push_back(24'h123457);
    exp_word.push_back(mem_word(24'h123456));
    cs_select(24'h123456);
    rd = 1'b0;
    repeat (12) @(negedge clk);
    check("late_drive", dut.r_drive_en, 1);
    rd = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b1;
    exp_count = exp_count + 25'd1;
    repeat (16) @(negedge clk);
    check("late_count", 32'(stat_ReadCount), 32'(exp_count));
    read_burst(24'h400000, 2, 2, 6, 9);

    // CS release coincides with mem_Ready during FETCH
    manual = 1'b1;
    exp_req.push_back(24'h777777);
    cs_select(24'h777777);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_Data = 16'hDEAD;
    mem_Ready = 1'b1;
    @(negedge clk);
    mem_Ready = 1'b0;
    check("race_req", mem_Request, 0);
    check("race_drive", dut.r_drive_en, 0);
    manual = 1'b0;
    repeat (10) @(negedge clk);
    check("race_count", 32'(stat_ReadCount), 32'(exp_count));
    read_burst(24'h000100, 1, 2, 8, 8);

    // CS2 never selects; WR pulse never drives or advances
    cs2 = 1'b0;
    repeat (10) @(negedge clk);
    cs2 = 1'b1;
    check("cs2_req", mem_Request, 0);
    mem_lat = 2;
    exp_req.push_back(24'h0A0B0C);
    exp_req.push_back(24'h0A0B0D);
    exp_word.push_back(mem_word(24'h0A0B0C));
    cs_select(24'h0A0B0C);
    repeat (8) @(negedge clk);
    wr = 1'b0;
    repeat (8) @(negedge clk);
    check("wr_nodrive", dut.r_drive_en, 0);
    wr = 1'b1;
    repeat (4) @(negedge clk);
    rd_pulse(8, 8);
    cs = 1'b1;
    exp_count = exp_count + 25'd1;
    repeat (12) @(negedge clk);
    check("wr_count", 32'(stat_ReadCount), 32'(exp_count));

    // randomized bursts
    for (int k = 0; k < 6; k++) begin
      ra  = 24'($urandom);
      rn  = $urandom_range(1, 4);
      rl  = $urandom_range(1, 6);
      rlo = $urandom_range(5, 10);
      rhi = rl + $urandom_range(6, 10);
      read_burst(ra, rn, rl, rlo, rhi);
    end

    // reset while driving
    mem_lat = 2;
    exp_req.push_back(24'h3C3C3C);
    exp_word.push_back(mem_word(24'h3C3C3C));
    cs_select(24'h3C3C3C);
    repeat (8) @(negedge clk);
    rd = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_drive", dut.r_drive_en, 1);
    reset = 1'b1;
    cs = 1'b1;
    rd = 1'b1;
    @(negedge clk);
    check("rst_drive_off", dut.r_drive_en, 0);
    check("rst_req_off", mem_Request, 0);
    check("rst_count_clr", 32'(stat_ReadCount), 0);
    check("rst_underrun_clr", stat_Underrun, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    exp_underrun = 1'b0;
    repeat (10) @(negedge clk);
    read_burst(24'h00ABC0, 2, 3, 7, 10);

    check("req_queue_empty", exp_req.size(), 0);
    check("word_queue_empty", exp_word.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gba_pak_emulator.md
Name: gba_pak_emulator

Overview:
- Cartridge-side responder for the GBA ROM bus: the block plays the pak that a bus initiator reads from.
- On CS falling it latches the 24-bit word address from the multiplexed AD[15:0] / A[23:16] pins.
- For every RD low pulse it drives one 16-bit word from a backing store, then auto-increments the address.
- Sits between the GBA-bus pins (test harness or real console) and a word-wide memory port (SDRAM/BRAM controller); used for loopback testing of the pak reader and for ROM emulation.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every bus input pin (RD, WR, CS, CS2, AD, A-hi); minimum 2.
- ADDR_BITS, 24, significant word-address bits; address increments wrap modulo 2^ADDR_BITS, upper bits of mem_Address forced 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pin_gbaRD  in  1  bus read strobe, active low
- pin_gbaWR  in  1  bus write strobe, active low; ROM writes ignored
- pin_gbaCS  in  1  ROM chip select, active low
- pin_gbaCS2  in  1  SRAM select; ignored, never causes driving
- pin_gbaDataAddressLo  inout  16  address low in / data out
- pin_gbaAddressHi  in  8  address bits 23:16
- mem_Address  out  24  word address requested from the backing store
- mem_Request  out  1  fetch request
- mem_Ready  in  1  fetch complete; mem_Data valid this cycle
- mem_Data  in  16  fetched word
- stat_ReadCount  out  25  words served since reset, saturating
- stat_Underrun  out  1  sticky: RD fell before the word was fetched

Behaviour:
- All pin inputs pass through SYNC_STAGES flops, all with the same delay. rd_s, cs_s and bus_s are the synchronized values; edges are detected on the synchronized values.
- AD drive: pin_gbaDataAddressLo = drive_en ? out_word : 16'dz. drive_en is a register. It is set only in state DRIVE while cs_s=0, rd_s=0 and the synchronized WR=1; otherwise it is 0.
- Reset values: drive_en=0, out_word=0, mem_Request=0, mem_Address=0, stat_ReadCount=0, stat_Underrun=0, state=IDLE. Reset mid-transfer drops mem_Request and drive_en in the next cycle; any later mem_Ready is ignored.
- IDLE: wait for a falling edge of cs_s. Then capture addr = {bus_s A-hi, bus_s AD} in the same cycle, masked to ADDR_BITS, and go to FETCH.
- FETCH:
  - mem_Request=1 with mem_Address=addr, both held stable until mem_Ready=1.
  - On mem_Ready: capture mem_Data into word_buf, set fetched=1, clear mem_Request on the next edge, go to WAIT_RD.
  - If rd_s falls while in FETCH: set stat_Underrun and mark the access; the word is driven as soon as fetched, while RD stays low.
- WAIT_RD: on a falling edge of rd_s, load out_word=word_buf and go to DRIVE. drive_en rises 1 cycle after the rd_s edge, i.e. SYNC_STAGES+1 clocks after the pin edge.
- DRIVE:
  - On a rising edge of rd_s: drive_en=0, addr=addr+1 (wrapping), stat_ReadCount++ (saturating at 2^25-1), fetched=0, go to FETCH. This prefetches the next word.
- CS release:
  - A rising edge of cs_s in any state returns to IDLE and forces drive_en=0 and mem_Request=0 on the next edge.
  - An outstanding fetch result is discarded.
  - CS rising and RD rising in the same cycle: CS wins; no increment, no count.
  - CS rising and mem_Ready in the same cycle: the data is discarded.
- Only one memory request is outstanding at a time; mem_Request never reasserts in the cycle after mem_Ready.
- WR low while CS is low: no drive, no state change. CS2 is fully ignored.
- Required host timing margin: the RD-low window must be at least SYNC_STAGES+2 clocks plus memory latency. Slower memory sets stat_Underrun; it never hangs the block.

Test Plan:
- Single read: AD=0x1234, A-hi=0x56, CS falls, RD pulses low for 12 clk; mem returns 0xBEEF after 3 clk. Required: mem_Address=0x561234, AD driven 0xBEEF from rd_s edge +1, released after RD rises, stat_ReadCount=1.
- Burst of 4 RD pulses from address 0x000010 with mem latency 1. Required: requests at 0x10, 0x11, 0x12, 0x13, 0x14 (last one is the prefetch); words driven in order; count=4; underrun=0.
- Wrap: start address 0xFFFFFF, two RD pulses. Required: second request at 0x000000.
- Underrun: mem latency 20 clk, RD low for 6 clk. Required: stat_Underrun=1 and sticky; the word is driven late only while RD is still low; no hang.
- CS rises during FETCH together with mem_Ready. Required: IDLE, drive_en=0, no count; the next CS/RD cycle operates normally.
- Reset asserted in DRIVE. Required: AD tristated and mem_Request=0 the next cycle; counters cleared. WR pulse or CS2 low never causes driving.
